// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment display scan controller:
// scan FSM state encodings and a width helper.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_st_e;

  // Never returns less than 1 so that counters for a count of 1 still get a real bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/pulse_rise.sv
// Rising-edge detector: one-cycle pulse on the first cycle the input is seen high.
module pulse_rise (
  input  logic clk,
  input  logic greset_n,
  input  logic in,
  output logic pulse
);

  logic hist;

  always_ff @(posedge clk or negedge greset_n) begin
    if (!greset_n) hist <= 1'b0;
    else           hist <= in;
  end

  assign pulse = in & ~hist;

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan scheduler: one digit per digsel tick, all-off dead
// time between digits, per-digit enable and qsec-timed blink gating.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int DEAD_CYC    = 2,
  parameter int BLINK_QSECS = 2
) (
  input  logic                     clk,
  input  logic                     greset_n,
  input  logic                     digsel,
  input  logic                     qsec,
  input  logic [4*NDIG-1:0]        data,
  input  logic [NDIG-1:0]          dp_in,
  input  logic [NDIG-1:0]          dig_en,
  input  logic [NDIG-1:0]          blink_mask,
  output logic [NDIG-1:0]          an,
  output logic [3:0]               nibble,
  output logic                     dp,
  output logic [clog2(NDIG)-1:0]   sel,
  output logic                     frame
);

  localparam int SEL_W  = clog2(NDIG);
  localparam int DEAD_W = clog2(DEAD_CYC);
  localparam int BC_W   = clog2(BLINK_QSECS);

  scan_st_e          state_q, state_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic [SEL_W-1:0]  sel_d, sel_inc;
  logic [3:0]        nib_d;
  logic              dp_d, frame_d;
  logic [NDIG-1:0]   an_d, an_lit;
  logic [BC_W-1:0]   blink_cnt;
  logic              blink_phase;
  logic              dig_rise, qsec_rise;

  pulse_rise u_digsel_rise (.clk(clk), .greset_n(greset_n), .in(digsel), .pulse(dig_rise));
  pulse_rise u_qsec_rise   (.clk(clk), .greset_n(greset_n), .in(qsec),   .pulse(qsec_rise));

  // Anode pattern for the digit currently held in sel, gated by enable and blink.
  always_comb begin
    an_lit      = '1;
    an_lit[sel] = !(dig_en[sel] && !(blink_phase && blink_mask[sel]));
  end

  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    sel_d   = sel;
    nib_d   = nibble;
    dp_d    = dp;
    frame_d = 1'b0;
    an_d    = '1;
    sel_inc = (sel == SEL_W'(NDIG - 1)) ? '0 : sel + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (dig_rise) begin
          state_d = ST_BLANK;
          sel_d   = '0;
          nib_d   = data[3:0];
          dp_d    = dp_in[0];
          dead_d  = '0;
        end
      end
      ST_BLANK: begin
        // Digit-advance ticks arriving here are intentionally dropped.
        if (dead_q == DEAD_W'(DEAD_CYC - 1)) begin
          state_d = ST_DRIVE;
          an_d    = an_lit;
        end else begin
          dead_d = dead_q + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (dig_rise) begin
          state_d = ST_BLANK;
          sel_d   = sel_inc;
          nib_d   = data[4*sel_inc +: 4];
          dp_d    = dp_in[sel_inc];
          dead_d  = '0;
          frame_d = (sel == SEL_W'(NDIG - 1));
        end else begin
          an_d = an_lit;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge greset_n) begin
    if (!greset_n) begin
      state_q <= ST_IDLE;
      dead_q  <= '0;
      sel     <= '0;
      nibble  <= '0;
      dp      <= 1'b0;
      frame   <= 1'b0;
      an      <= '1;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
      sel     <= sel_d;
      nibble  <= nib_d;
      dp      <= dp_d;
      frame   <= frame_d;
      an      <= an_d;
    end
  end

  // Blink timebase runs independently of the scan FSM.
  always_ff @(posedge clk or negedge greset_n) begin
    if (!greset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (qsec_rise) begin
      if (blink_cnt == BC_W'(BLINK_QSECS - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule
